vreg_file_bank: RTL and testbench

//   Vector register file bank that consumes the beat stream from the address generator.

---
 rtl/vreg_file_bank.sv | 207 ++++++++++++++++++++
 tb/tb_vreg_file_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_file_bank.sv
// Vector register file bank: byte-masked writeback, a 1- or 2-cycle read pipeline,
// and a read-frame checker that tags framing errors and reports frame beat counts.
module vreg_file_bank #(
    parameter int unsigned VLEN       = 16384,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned OFF_WIDTH  = 8,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [OFF_WIDTH-1:0]    rd_off,
    input  logic                    rd_start,
    input  logic                    rd_end,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [OFF_WIDTH-1:0]    wr_off,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_first,
    output logic                    rd_last,
    output logic                    rd_err,
    output logic [OFF_WIDTH+2:0]    rd_beats,
    output logic                    busy
);

    localparam int unsigned WORDS = VLEN / DATA_WIDTH;
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = ADDR_WIDTH + OFF_WIDTH;
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned CNT_W = OFF_WIDTH + 3;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_e;

    state_e             state;
    state_e             next_state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   next_count;
    logic [CNT_W-1:0]   count_inc_c;
    logic [CNT_W-1:0]   beats_c;
    logic               frame_err_c;

    logic [IDX_W-1:0]       rd_idx_c;
    logic [IDX_W-1:0]       wr_idx_c;
    logic                   rd_ok_c;
    logic                   wr_ok_c;
    logic [DATA_WIDTH-1:0]  wr_mask_c;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   s1_valid;
    logic [DATA_WIDTH-1:0]  s1_data;
    logic                   s1_first;
    logic                   s1_last;
    logic                   s1_err;
    logic [CNT_W-1:0]       s1_beats;

    assign rd_idx_c = {rd_addr, rd_off};
    assign wr_idx_c = {wr_addr, wr_off};
    assign rd_ok_c  = 32'(rd_off) < WORDS;
    assign wr_ok_c  = 32'(wr_off) < WORDS;

    // Byte enables widened to a bit mask for the read-modify-write merge.
    for (genvar b = 0; b < BYTES; b++) begin : g_mask
        assign wr_mask_c[8*b +: 8] = {8{wr_be[b]}};
    end

    always_ff @(posedge clk) begin : mem_write
        if (wr_en && wr_ok_c) begin
            mem[wr_idx_c] <= (mem[wr_idx_c] & ~wr_mask_c) | (wr_data & wr_mask_c);
        end
    end

    assign count_inc_c = (&count) ? count : count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin : frame_state
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // A closed frame always leaves the count at zero.
    always_comb begin : frame_next
        next_state  = state;
        next_count  = count;
        frame_err_c = 1'b0;
        beats_c     = '0;
        if (rd_en) begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        next_state = rd_end ? IDLE : FRAME;
                        next_count = rd_end ? '0 : CNT_W'(1);
                        if (rd_end) begin
                            beats_c = CNT_W'(1);
                        end
                    end else begin
                        frame_err_c = 1'b1;
                        if (rd_end) begin
                            beats_c = count;
                        end
                    end
                end
                FRAME: begin
                    if (rd_start) begin
                        frame_err_c = 1'b1;
                        next_state  = rd_end ? IDLE : FRAME;
                        next_count  = rd_end ? '0 : CNT_W'(1);
                        if (rd_end) begin
                            beats_c = CNT_W'(1);
                        end
                    end else if (rd_end) begin
                        next_state = IDLE;
                        next_count = '0;
                        beats_c    = count_inc_c;
                    end else begin
                        next_count = count_inc_c;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == FRAME);

    // Read stage: storage read is read-first against a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin : read_stage
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_beats <= '0;
        end else if (rd_en) begin
            s1_valid <= 1'b1;
            s1_data  <= rd_ok_c ? mem[rd_idx_c] : '0;
            s1_first <= rd_start;
            s1_last  <= rd_end;
            s1_err   <= frame_err_c | ~rd_ok_c;
            s1_beats <= beats_c;
        end else begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_beats <= '0;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                   s2_valid;
        logic [DATA_WIDTH-1:0]  s2_data;
        logic                   s2_first;
        logic                   s2_last;
        logic                   s2_err;
        logic [CNT_W-1:0]       s2_beats;

        always_ff @(posedge clk or negedge rst_n) begin : out_stage
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
                s2_first <= 1'b0;
                s2_last  <= 1'b0;
                s2_err   <= 1'b0;
                s2_beats <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_data  <= s1_data;
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_err   <= s1_err;
                s2_beats <= s1_beats;
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
        assign rd_first = s2_first;
        assign rd_last  = s2_last;
        assign rd_err   = s2_err;
        assign rd_beats = s2_beats;
    end else begin : g_no_out_reg
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
        assign rd_first = s1_first;
        assign rd_last  = s1_last;
        assign rd_err   = s1_err;
        assign rd_beats = s1_beats;
    end

endmodule

// File: tb/tb_vreg_file_bank.sv
// Bench for vreg_file_bank: directed vector table, reset/saturation sequences and
// random traffic, all checked against a frame-level reference model (latency 1 and 2).
module tb_vreg_file_bank;

    localparam int WORDS   = 256;
    localparam int CNT_MAX = 2047;

    typedef struct {
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic [7:0]  rd_off;
        logic        rd_start;
        logic        rd_end;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [7:0]  wr_off;
        logic [7:0]  wr_be;
        logic [63:0] wr_data;
    } in_t;

    typedef struct {
        logic        valid;
        logic [63:0] data;
        logic        dknown;
        logic        first;
        logic        last;
        logic        err;
        logic [10:0] beats;
    } out_t;

    typedef struct {
        in_t         i;
        out_t        e;
        logic        busy;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        rd_en, rd_start, rd_end, wr_en;
    logic [4:0]  rd_addr, wr_addr;
    logic [7:0]  rd_off, wr_off, wr_be;
    logic [63:0] wr_data;

    logic        valid0, first0, last0, err0, busy0;
    logic [63:0] data0;
    logic [10:0] beats0;
    logic        valid1, first1, last1, err1, busy1;
    logic [63:0] data1;
    logic [10:0] beats1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [63:0] m_mem   [8192];
    bit          m_known [8192];
    bit          m_open;
    int          m_cnt;
    out_t        e_prev;

    vreg_file_bank #(.OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_off(rd_off), .rd_start(rd_start), .rd_end(rd_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_off(wr_off), .wr_be(wr_be), .wr_data(wr_data),
        .rd_valid(valid0), .rd_data(data0), .rd_first(first0), .rd_last(last0),
        .rd_err(err0), .rd_beats(beats0), .busy(busy0)
    );

    vreg_file_bank #(.OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_off(rd_off), .rd_start(rd_start), .rd_end(rd_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_off(wr_off), .wr_be(wr_be), .wr_data(wr_data),
        .rd_valid(valid1), .rd_data(data1), .rd_first(first1), .rd_last(last1),
        .rd_err(err1), .rd_beats(beats1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t vin(input logic re, input int ra, input int ro, input logic rs,
                                input logic rend, input logic we, input int wa, input int wo,
                                input logic [7:0] be, input logic [63:0] wd);
        in_t v;
        v.rd_en = re;  v.rd_addr = 5'(ra); v.rd_off = 8'(ro); v.rd_start = rs; v.rd_end = rend;
        v.wr_en = we;  v.wr_addr = 5'(wa); v.wr_off = 8'(wo); v.wr_be = be;   v.wr_data = wd;
        return v;
    endfunction

    function automatic out_t vout(input logic v, input logic [63:0] d, input logic f,
                                  input logic l, input logic e, input int b);
        out_t o;
        o.valid = v; o.data = d; o.dknown = 1'b1; o.first = f; o.last = l; o.err = e;
        o.beats = 11'(b);
        return o;
    endfunction

    function automatic in_t rdv(input int a, input int o, input logic s, input logic e);
        return vin(1'b1, a, o, s, e, 1'b0, 0, 0, 8'h00, 64'h0);
    endfunction

    function automatic in_t wrv(input int a, input int o, input logic [7:0] be, input logic [63:0] d);
        return vin(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, a, o, be, d);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input in_t v);
        rd_en = v.rd_en; rd_addr = v.rd_addr; rd_off = v.rd_off;
        rd_start = v.rd_start; rd_end = v.rd_end;
        wr_en = v.wr_en; wr_addr = v.wr_addr; wr_off = v.wr_off;
        wr_be = v.wr_be; wr_data = v.wr_data;
    endtask

    // Frame-level model: a frame is open or closed and has a saturating beat tally.
    task automatic model_beat(input in_t v, output out_t o);
        int idx;
        o = vout(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 0);
        if (v.rd_en) begin
            idx     = int'({v.rd_addr, v.rd_off});
            o.valid = 1'b1;
            o.first = v.rd_start;
            o.last  = v.rd_end;
            if (int'(v.rd_off) >= WORDS) begin
                o.err = 1'b1;
            end else begin
                o.data   = m_mem[idx];
                o.dknown = m_known[idx];
            end
            if (v.rd_start) begin
                if (m_open) o.err = 1'b1;
                m_cnt  = 1;
                m_open = !v.rd_end;
            end else if (!m_open) begin
                o.err = 1'b1;
            end else begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (v.rd_end) m_open = 1'b0;
            end
            if (v.rd_end) o.beats = 11'(m_cnt);
            if (!m_open) m_cnt = 0;
        end
        if (v.wr_en && int'(v.wr_off) < WORDS) begin
            idx = int'({v.wr_addr, v.wr_off});
            for (int b = 0; b < 8; b++) begin
                if (v.wr_be[b]) m_mem[idx][8*b +: 8] = v.wr_data[8*b +: 8];
            end
            m_known[idx] = 1'b1;
        end
    endtask

    task automatic cmp_out(input string name, input logic v, input logic [63:0] d, input logic f,
                           input logic l, input logic e, input logic [10:0] b, input out_t x);
        check({name, ".ctrl"}, 64'({v, f, l, e, b}), 64'({x.valid, x.first, x.last, x.err, x.beats}));
        if (x.dknown) check({name, ".data"}, d, x.data);
    endtask

    // One clock: drive, advance model, then compare both latencies just after the edge.
    task automatic cycle(input in_t v);
        out_t e;
        apply(v);
        model_beat(v, e);
        @(posedge clk);
        #1;
        cmp_out("dut0", valid0, data0, first0, last0, err0, beats0, e);
        cmp_out("dut1", valid1, data1, first1, last1, err1, beats1, e_prev);
        check("busy0", 64'(busy0), 64'(m_open));
        check("busy1", 64'(busy1), 64'(m_open));
        e_prev = e;
    endtask

    vec_t tbl[$];

    task automatic add(input in_t i, input out_t e, input logic bsy);
        vec_t t;
        t.i = i; t.e = e; t.busy = bsy;
        tbl.push_back(t);
    endtask

    initial begin
        in_t  idle;
        out_t z;
        idle = vin(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00, 64'h0);
        z    = vout(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 0);
        m_open = 1'b0;
        m_cnt  = 0;
        e_prev = z;
        rst_n  = 1'b0;
        apply(idle);

        repeat (2) @(posedge clk);
        #1;
        check("rst.valid0", 64'(valid0), 64'd0);
        check("rst.valid1", 64'(valid1), 64'd0);
        check("rst.data0", data0, 64'd0);
        check("rst.beats0", 64'(beats0), 64'd0);
        check("rst.busy0", 64'(busy0), 64'd0);
        rst_n = 1'b1;

        // Directed vectors: {inputs, expected latency-1 outputs, busy}
        for (int k = 0; k < 4; k++)
            add(wrv(3, k, 8'hFF, 64'(8'hA0 + k)), z, 1'b0);
        add(rdv(3, 0, 1'b1, 1'b0), vout(1'b1, 64'hA0, 1'b1, 1'b0, 1'b0, 0), 1'b1);
        add(rdv(3, 1, 1'b0, 1'b0), vout(1'b1, 64'hA1, 1'b0, 1'b0, 1'b0, 0), 1'b1);
        add(rdv(3, 2, 1'b0, 1'b0), vout(1'b1, 64'hA2, 1'b0, 1'b0, 1'b0, 0), 1'b1);
        add(rdv(3, 3, 1'b0, 1'b1), vout(1'b1, 64'hA3, 1'b0, 1'b1, 1'b0, 4), 1'b0);
        add(wrv(5, 7, 8'hFF, 64'h1111_1111_1111_1111), z, 1'b0);
        add(wrv(5, 7, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF), z, 1'b0);
        add(rdv(5, 7, 1'b1, 1'b1), vout(1'b1, 64'h1111_1111_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1), 1'b0);
        add(wrv(6, 2, 8'hFF, 64'h22), z, 1'b0);
        add(vin(1'b1, 6, 2, 1'b1, 1'b1, 1'b1, 6, 2, 8'hFF, 64'h55),
            vout(1'b1, 64'h22, 1'b1, 1'b1, 1'b0, 1), 1'b0);
        add(rdv(6, 2, 1'b1, 1'b1), vout(1'b1, 64'h55, 1'b1, 1'b1, 1'b0, 1), 1'b0);
        add(rdv(3, 0, 1'b0, 1'b0), vout(1'b1, 64'hA0, 1'b0, 1'b0, 1'b1, 0), 1'b0);
        add(rdv(3, 0, 1'b1, 1'b0), vout(1'b1, 64'hA0, 1'b1, 1'b0, 1'b0, 0), 1'b1);
        add(rdv(3, 1, 1'b0, 1'b0), vout(1'b1, 64'hA1, 1'b0, 1'b0, 1'b0, 0), 1'b1);
        add(rdv(3, 2, 1'b1, 1'b0), vout(1'b1, 64'hA2, 1'b1, 1'b0, 1'b1, 0), 1'b1);
        add(rdv(3, 3, 1'b0, 1'b1), vout(1'b1, 64'hA3, 1'b0, 1'b1, 1'b0, 2), 1'b0);

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].i);
            check($sformatf("tbl%0d.ctrl", k), 64'({valid0, first0, last0, err0, beats0}),
                  64'({tbl[k].e.valid, tbl[k].e.first, tbl[k].e.last, tbl[k].e.err, tbl[k].e.beats}));
            check($sformatf("tbl%0d.data", k), data0, tbl[k].e.data);
            check($sformatf("tbl%0d.busy", k), 64'(busy0), 64'(tbl[k].busy));
        end
        cycle(idle);
        cycle(idle);

        // Reset in the middle of an open frame clears outputs and busy immediately.
        cycle(rdv(3, 0, 1'b1, 1'b0));
        cycle(rdv(3, 1, 1'b0, 1'b0));
        apply(idle);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.valid0", 64'(valid0), 64'd0);
        check("midrst.valid1", 64'(valid1), 64'd0);
        check("midrst.busy0", 64'(busy0), 64'd0);
        check("midrst.busy1", 64'(busy1), 64'd0);
        check("midrst.data0", data0, 64'd0);
        m_open = 1'b0;
        m_cnt  = 0;
        e_prev = z;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(rdv(3, 2, 1'b1, 1'b1));
        check("postrst.err0", 64'(err0), 64'd0);
        check("postrst.data0", data0, 64'hA2);
        cycle(idle);
        check("postrst.err1", 64'(err1), 64'd0);
        check("postrst.data1", data1, 64'hA2);

        // Long frame: beat count saturates at all-ones.
        cycle(rdv(3, 0, 1'b1, 1'b0));
        for (int k = 1; k < 2099; k++) cycle(rdv(3, k % 4, 1'b0, 1'b0));
        cycle(rdv(3, 3, 1'b0, 1'b1));
        check("sat.beats0", 64'(beats0), 64'(CNT_MAX));
        check("sat.last0", 64'(last0), 64'd1);
        cycle(idle);
        check("sat.beats1", 64'(beats1), 64'(CNT_MAX));

        // Random traffic over a small address window to force collisions and framing errors.
        for (int k = 0; k < 800; k++) begin
            in_t v;
            v = vin($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 7),
                    $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 7),
                    8'($urandom), {$urandom, $urandom});
            cycle(v);
        end
        cycle(idle);
        cycle(idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
